// File: rtl/burst_sequencer.sv
// burst_sequencer: expands one read/write command into a burst of per-cycle beats
// on the per-bank DRAM chip ports and returns read beats in order. Optional: BURST_CHOP_EN.
module burst_sequencer #(
  parameter int BGWIDTH      = 2,
  parameter int BAWIDTH      = 2,
  parameter int COLWIDTH     = 10,
  parameter int CHWIDTH      = 5,
  parameter int DEVICE_WIDTH = 4,
  parameter int BL           = 8,
  parameter int RD_LAT       = 1,
  localparam int BANKGROUPS    = 2**BGWIDTH,
  localparam int BANKSPERGROUP = 2**BAWIDTH
) (
  input  logic                                                         clk,
  input  logic                                                         reset,
  input  logic                                                         cmd_valid,
  output logic                                                         cmd_ready,
  input  logic                                                         cmd_write,
`ifdef BURST_CHOP_EN
  input  logic                                                         cmd_bc4,
`endif
  input  logic [BGWIDTH-1:0]                                           cmd_bg,
  input  logic [BAWIDTH-1:0]                                           cmd_ba,
  input  logic [CHWIDTH-1:0]                                           cmd_row,
  input  logic [COLWIDTH-1:0]                                          cmd_col,
  input  logic [DEVICE_WIDTH-1:0]                                      wr_data,
  input  logic                                                         wr_valid,
  output logic                                                         wr_ready,
  output logic [DEVICE_WIDTH-1:0]                                      rd_data,
  output logic                                                         rd_valid,
  output logic                                                         rd_last,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                     rd_o_wr,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][CHWIDTH-1:0]        row,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][COLWIDTH-1:0]       column,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0]   dqin,
  input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0]   dqout
);

  localparam int             LBL       = $clog2(BL);
  localparam logic [LBL-1:0] LAST_FULL = '1;
  localparam logic [LBL-1:0] LAST_BC4  = LBL'(3);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  state_t                r_state, w_state_next;
  logic [LBL-1:0]        r_beat, w_beat_next;
  logic [BGWIDTH-1:0]    r_bg;
  logic [BAWIDTH-1:0]    r_ba;
  logic [CHWIDTH-1:0]    r_row;
  logic [COLWIDTH-1:0]   r_col;
  logic                  w_bc4;
  logic                  w_accept, w_issue, w_write_beat, w_is_last;
  logic [LBL-1:0]        w_last_beat, w_mask, w_low_sum;
  logic [COLWIDTH-1:0]   w_beat_col;

  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                   r_rd_o_wr, w_rd_o_wr_n;
  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][CHWIDTH-1:0]      r_row_o, w_row_n;
  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][COLWIDTH-1:0]     r_col_o, w_col_n;
  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0] r_dqin, w_dqin_n;

  logic [RD_LAT:0]          r_pv, r_pl;
  logic                     r_smp_v, r_smp_l;
  logic [DEVICE_WIDTH-1:0]  r_smp_d;
  logic                     r_rd_valid, r_rd_last;
  logic [DEVICE_WIDTH-1:0]  r_rd_data;

`ifdef BURST_CHOP_EN
  logic r_bc4;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_bc4 <= 1'b0;
    else if (w_accept) r_bc4 <= cmd_bc4;
  end
  assign w_bc4 = r_bc4;
`else
  assign w_bc4 = 1'b0;
`endif

  // A chopped burst wraps inside a 4-aligned block, a full one inside a BL-aligned block.
  assign w_last_beat = w_bc4 ? LAST_BC4 : LAST_FULL;
  assign w_mask      = w_bc4 ? LAST_BC4 : LAST_FULL;
  assign w_is_last   = (r_beat == w_last_beat);
  assign w_low_sum   = r_col[LBL-1:0] + r_beat;
  assign w_beat_col  = {r_col[COLWIDTH-1:LBL], (r_col[LBL-1:0] & ~w_mask) | (w_low_sum & w_mask)};

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_write_beat = 1'b0;
    case (r_state)
      S_IDLE: if (cmd_valid) begin
        w_accept     = 1'b1;
        w_state_next = cmd_write ? S_WRITE : S_READ;
      end
      S_WRITE: if (wr_valid) begin
        w_issue      = 1'b1;
        w_write_beat = 1'b1;
        if (w_is_last) w_state_next = S_IDLE;
      end
      S_READ: begin
        w_issue = 1'b1;
        if (w_is_last) w_state_next = S_DRAIN;
      end
      S_DRAIN: if (r_rd_valid && r_rd_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    w_beat_next = r_beat;
    if (w_accept)     w_beat_next = '0;
    else if (w_issue) w_beat_next = w_is_last ? '0 : r_beat + 1'b1;
  end

  // Only the selected bank is ever non-zero; a write stall holds row/column, drops strobe and data.
  always_comb begin
    w_rd_o_wr_n = '0;
    w_row_n     = '0;
    w_col_n     = '0;
    w_dqin_n    = '0;
    if (w_issue) begin
      w_rd_o_wr_n[r_bg][r_ba] = w_write_beat;
      w_row_n[r_bg][r_ba]     = r_row;
      w_col_n[r_bg][r_ba]     = w_beat_col;
      w_dqin_n[r_bg][r_ba]    = w_write_beat ? wr_data : '0;
    end else if (r_state == S_WRITE) begin
      w_row_n[r_bg][r_ba] = r_row_o[r_bg][r_ba];
      w_col_n[r_bg][r_ba] = r_col_o[r_bg][r_ba];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_next;
      r_beat  <= w_beat_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bg  <= '0;
      r_ba  <= '0;
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      r_bg  <= cmd_bg;
      r_ba  <= cmd_ba;
      r_row <= cmd_row;
      r_col <= cmd_col;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_o_wr <= '0;
      r_row_o   <= '0;
      r_col_o   <= '0;
      r_dqin    <= '0;
    end else begin
      r_rd_o_wr <= w_rd_o_wr_n;
      r_row_o   <= w_row_n;
      r_col_o   <= w_col_n;
      r_dqin    <= w_dqin_n;
    end
  end

  // Stage 0 lines up with the driven column; stage RD_LAT lines up with valid dqout.
  // The bank select stays stable because no new command is taken until the pipe drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pv       <= '0;
      r_pl       <= '0;
      r_smp_v    <= 1'b0;
      r_smp_l    <= 1'b0;
      r_smp_d    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_pv       <= {r_pv[RD_LAT-1:0], w_issue & ~w_write_beat};
      r_pl       <= {r_pl[RD_LAT-1:0], w_issue & ~w_write_beat & w_is_last};
      r_smp_v    <= r_pv[RD_LAT];
      r_smp_l    <= r_pl[RD_LAT];
      r_smp_d    <= r_pv[RD_LAT] ? dqout[r_bg][r_ba] : '0;
      r_rd_valid <= r_smp_v;
      r_rd_last  <= r_smp_l;
      r_rd_data  <= r_smp_d;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign wr_ready  = (r_state == S_WRITE);
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  assign rd_data   = r_rd_data;
  assign rd_o_wr   = r_rd_o_wr;
  assign row       = r_row_o;
  assign column    = r_col_o;
  assign dqin      = r_dqin;

endmodule
